// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART frame receiver and its byte-level front end.
package uart_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} frame_state_t;

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byte_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: samples each bit at its centre and pulses rx_done after a valid stop bit.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done
);

  localparam int CW   = $clog2(CLKS_PER_BIT + 1);
  localparam int HALF = (CLKS_PER_BIT > 1) ? (CLKS_PER_BIT / 2 - 1) : 0;

  logic          rx_meta;
  logic          rx_sync;
  byte_state_t   state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= B_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      rx_data <= '0;
      rx_done <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (state)
        B_IDLE: begin
          cnt <= '0;
          if (!rx_sync) state <= B_START;
        end
        B_START: begin
          // A start bit that is no longer low at its centre was a glitch.
          if (cnt == CW'(HALF)) begin
            cnt <= '0;
            if (!rx_sync) begin
              state   <= B_DATA;
              bit_idx <= '0;
            end else begin
              state <= B_IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        B_DATA: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt   <= '0;
            shift <= {rx_sync, shift[7:1]};
            if (bit_idx == 3'd7) state <= B_STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        B_STOP: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt   <= '0;
            state <= B_IDLE;
            if (rx_sync) begin
              rx_done <= 1'b1;
              rx_data <= shift;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= B_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_frame_rx.sv
// Sync-delimited, XOR-checksummed UART frame receiver with an inter-byte timeout and a
// one-frame valid/ready holding register.
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter int         CLK_FREQ     = 50000000,
  parameter int         BAUD_RATE    = 115200,
  parameter int         CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE),
  parameter int         NUM_WORDS    = 4,
  parameter int         WORD_BYTES   = 2,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_BITS = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                rx,
  output logic [NUM_WORDS*WORD_BYTES*8-1:0]   data_out,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                chk_err,
  output logic                                timeout_err,
  output logic                                overrun,
  output logic [15:0]                         frame_count
);

  localparam int NBYTES       = NUM_WORDS * WORD_BYTES;
  localparam int DW           = NBYTES * 8;
  localparam int IW           = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int GW           = $clog2(TIMEOUT_CLKS + 1);

  logic [7:0]    rx_data;
  logic          rx_done;
  frame_state_t  state;
  logic [IW-1:0] idx;
  logic [7:0]    csum;
  logic [GW-1:0] gap;
  logic [DW-1:0] stage;

  uart_byte_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_rx (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx),
    .rx_data(rx_data),
    .rx_done(rx_done)
  );

  // Frame FSM plus holding register; a consume and a new load in the same cycle keep out_valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      idx         <= '0;
      csum        <= '0;
      gap         <= '0;
      stage       <= '0;
      data_out    <= '0;
      out_valid   <= 1'b0;
      chk_err     <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
      frame_count <= '0;
    end else begin
      chk_err     <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;

      case (state)
        HUNT: begin
          gap <= '0;
          if (rx_done && (rx_data == SYNC_BYTE)) begin
            state <= PAYLOAD;
            idx   <= '0;
            csum  <= '0;
          end
        end
        PAYLOAD, CHECK: begin
          if (rx_done) begin
            gap <= '0;
            if (state == PAYLOAD) begin
              for (int i = 0; i < NBYTES; i++) begin
                if (idx == IW'(i)) stage[i*8 +: 8] <= rx_data;
              end
              csum <= csum ^ rx_data;
              if (idx == IW'(NBYTES - 1)) state <= CHECK;
              else idx <= idx + IW'(1);
            end else begin
              state <= HUNT;
              if (rx_data != csum) begin
                chk_err <= 1'b1;
              end else if (out_valid && !out_ready) begin
                overrun <= 1'b1;
              end else begin
                data_out    <= stage;
                out_valid   <= 1'b1;
                frame_count <= frame_count + 16'd1;
              end
            end
          end else if (gap == GW'(TIMEOUT_CLKS - 1)) begin
            timeout_err <= 1'b1;
            state       <= HUNT;
            gap         <= '0;
          end else begin
            gap <= gap + GW'(1);
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: a frame-level model compared every cycle, plus literal pins.
module tb_uart_frame_rx;

  localparam int         CLK_FREQ = 1000000;
  localparam int         BAUD     = 125000;
  localparam int         CPB      = CLK_FREQ / BAUD;
  localparam logic [7:0] SYNC     = 8'hA5;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rx_line;
  logic [1:0]  out_ready;
  logic [1:0]  out_valid;
  logic [1:0]  chk_err;
  logic [1:0]  timeout_err;
  logic [1:0]  overrun;
  logic [63:0] data0;
  logic [95:0] data1;
  logic [15:0] count0;
  logic [15:0] count1;

  int assert_count = 0;
  int fail_count   = 0;
  logic settle   = 1'b1;
  logic checking = 1'b0;

  // Frame-level model state, per DUT
  logic         exp_valid [2];
  logic [127:0] exp_data  [2];
  int           exp_count [2];
  int           exp_chk   [2];
  int           exp_to    [2];
  int           exp_ov    [2];
  int           obs_chk   [2];
  int           obs_to    [2];
  int           obs_ov    [2];

  logic [7:0] frame_bytes [0:15];

  always #5 clk = ~clk;

  uart_frame_rx #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .NUM_WORDS(4), .WORD_BYTES(2)
  ) dut0 (
    .clk(clk), .rst(rst), .rx(rx_line[0]), .data_out(data0), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .chk_err(chk_err[0]), .timeout_err(timeout_err[0]),
    .overrun(overrun[0]), .frame_count(count0)
  );

  uart_frame_rx #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .NUM_WORDS(3), .WORD_BYTES(4)
  ) dut1 (
    .clk(clk), .rst(rst), .rx(rx_line[1]), .data_out(data1), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .chk_err(chk_err[1]), .timeout_err(timeout_err[1]),
    .overrun(overrun[1]), .frame_count(count1)
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    assert_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] dutData(input int d);
    return (d == 0) ? {64'b0, data0} : {32'b0, data1};
  endfunction

  function automatic logic [15:0] dutCount(input int d);
    return (d == 0) ? count0 : count1;
  endfunction

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      exp_valid[d] = 1'b0;
      exp_data[d]  = '0;
      exp_count[d] = 0;
    end
  endtask

  // A complete frame: bad checksum drops it, a full holding register overruns, else it is held.
  task automatic modelFrame(input int d, input int n, input logic [7:0] chk);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < n; i++) x ^= frame_bytes[i];
    if (chk != x) begin
      exp_chk[d]++;
    end else if (exp_valid[d]) begin
      exp_ov[d]++;
    end else begin
      exp_data[d] = '0;
      for (int i = 0; i < n; i++) exp_data[d][i*8 +: 8] = frame_bytes[i];
      exp_valid[d] = 1'b1;
      exp_count[d] = (exp_count[d] + 1) % 65536;
    end
  endtask

  task automatic sendByte(input int d, input logic [7:0] b);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_line[d] = bits[i];
      repeat (CPB) @(negedge clk);
    end
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic loadBytes(input logic [127:0] v, input int n);
    for (int i = 0; i < n; i++) frame_bytes[i] = v[i*8 +: 8];
  endtask

  task automatic applyStimulus(input int d, input int n, input logic corrupt);
    logic [7:0] x = 8'h00;
    logic [7:0] chk;
    for (int i = 0; i < n; i++) x ^= frame_bytes[i];
    chk = corrupt ? (x ^ 8'h01) : x;
    sendByte(d, SYNC);
    for (int i = 0; i < n; i++) sendByte(d, frame_bytes[i]);
    settle = 1'b1;
    sendByte(d, chk);
    modelFrame(d, n, chk);
    settle = 1'b0;
  endtask

  task automatic consume(input int d);
    settle = 1'b1;
    out_ready[d] = 1'b1;
    @(negedge clk);
    exp_valid[d] = 1'b0;
    out_ready[d] = 1'b0;
    settle = 1'b0;
  endtask

  task automatic pulseReset();
    settle = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    modelReset();
    @(negedge clk);
    settle = 1'b0;
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (chk_err[d]) obs_chk[d]++;
      if (timeout_err[d]) obs_to[d]++;
      if (overrun[d]) obs_ov[d]++;
    end
  end

  // Every cycle: model comparison when settled, pulse rules always.
  logic [1:0] prev_valid = '0;
  logic [1:0] prev_chk = '0;
  logic [1:0] prev_to = '0;
  logic [1:0] prev_ov = '0;
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (checking) begin
        for (int d = 0; d < 2; d++) begin
          if (!settle) begin
            checkOutput($sformatf("valid%0d", d), {127'b0, out_valid[d]}, {127'b0, exp_valid[d]});
            checkOutput($sformatf("data%0d", d), dutData(d), exp_data[d]);
            checkOutput($sformatf("count%0d", d), {112'b0, dutCount(d)}, 128'(exp_count[d]));
            checkOutput($sformatf("chk_pulses%0d", d), 128'(obs_chk[d]), 128'(exp_chk[d]));
            checkOutput($sformatf("to_pulses%0d", d), 128'(obs_to[d]), 128'(exp_to[d]));
            checkOutput($sformatf("ov_pulses%0d", d), 128'(obs_ov[d]), 128'(exp_ov[d]));
          end
          checkOutput($sformatf("err_exclusive%0d", d),
                      {127'b0, $onehot0({chk_err[d], timeout_err[d], overrun[d]})}, 128'd1);
          checkOutput($sformatf("err_vs_rise%0d", d),
                      {127'b0, (chk_err[d] | timeout_err[d] | overrun[d]) & out_valid[d] & ~prev_valid[d]}, 128'd0);
          checkOutput($sformatf("pulse_width%0d", d),
                      {127'b0, (chk_err[d] & prev_chk[d]) | (timeout_err[d] & prev_to[d]) | (overrun[d] & prev_ov[d])}, 128'd0);
        end
      end
      prev_valid = out_valid;
      prev_chk   = chk_err;
      prev_to    = timeout_err;
      prev_ov    = overrun;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    rx_line   = 2'b11;
    out_ready = 2'b00;
    for (int d = 0; d < 2; d++) begin
      exp_chk[d] = 0; exp_to[d] = 0; exp_ov[d] = 0;
      obs_chk[d] = 0; obs_to[d] = 0; obs_ov[d] = 0;
    end
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("reset_valid0", {127'b0, out_valid[0]}, 128'd0);
    checkOutput("reset_data0", {64'b0, data0}, 128'd0);
    checkOutput("reset_count0", {112'b0, count0}, 128'd0);
    rst = 1'b0;
    @(negedge clk);
    checking = 1'b1;
    settle   = 1'b0;

    $display("[TB] default frame");
    loadBytes(128'hDEF0_9ABC_5678_1234, 8);
    applyStimulus(0, 8, 1'b0);
    checkOutput("frameA_data", {64'b0, data0}, {64'b0, 64'hDEF0_9ABC_5678_1234});
    checkOutput("frameA_count", {112'b0, count0}, 128'd1);
    checkOutput("frameA_noerr", 128'(obs_chk[0] + obs_to[0] + obs_ov[0]), 128'd0);
    consume(0);

    $display("[TB] bad checksum then good frame");
    applyStimulus(0, 8, 1'b1);
    checkOutput("badchk_pulse", 128'(obs_chk[0]), 128'd1);
    checkOutput("badchk_valid", {127'b0, out_valid[0]}, 128'd0);
    checkOutput("badchk_count", {112'b0, count0}, 128'd1);
    loadBytes(128'h8877_6655_4433_2211, 8);
    applyStimulus(0, 8, 1'b0);
    checkOutput("frameB_data", {64'b0, data0}, {64'b0, 64'h8877_6655_4433_2211});
    consume(0);

    $display("[TB] truncated frame timeout");
    sendByte(0, SYNC);
    sendByte(0, 8'h34);
    sendByte(0, 8'h12);
    sendByte(0, 8'h78);
    settle = 1'b1;
    repeat (40 * CPB) @(negedge clk);
    exp_to[0]++;
    settle = 1'b0;
    @(negedge clk);
    checkOutput("timeout_pulse", 128'(obs_to[0]), 128'd1);
    loadBytes(128'hEFCD_AB89_6745_2301, 8);
    applyStimulus(0, 8, 1'b0);
    checkOutput("frameC_data", {64'b0, data0}, {64'b0, 64'hEFCD_AB89_6745_2301});
    consume(0);

    $display("[TB] overrun with out_ready low");
    loadBytes(128'hDEF0_9ABC_5678_1234, 8);
    applyStimulus(0, 8, 1'b0);
    loadBytes(128'h8877_6655_4433_2211, 8);
    applyStimulus(0, 8, 1'b0);
    checkOutput("overrun_pulse", 128'(obs_ov[0]), 128'd1);
    checkOutput("overrun_data", {64'b0, data0}, {64'b0, 64'hDEF0_9ABC_5678_1234});
    consume(0);
    checkOutput("overrun_release", {127'b0, out_valid[0]}, 128'd0);

    $display("[TB] leading garbage and sync bytes inside payload");
    sendByte(0, 8'h00);
    sendByte(0, 8'hFF);
    sendByte(0, 8'h5A);
    loadBytes(128'h5544_A533_22A5_11A5, 8);
    applyStimulus(0, 8, 1'b0);
    checkOutput("garbage_data", {64'b0, data0}, {64'b0, 64'h5544_A533_22A5_11A5});
    consume(0);

    $display("[TB] three 32-bit words, then reset mid-frame");
    loadBytes(128'h0C0B0A09_08070605_04030201, 12);
    applyStimulus(1, 12, 1'b0);
    checkOutput("wide_data", {32'b0, data1}, {32'b0, 96'h0C0B0A09_08070605_04030201});
    checkOutput("wide_count", {112'b0, count1}, 128'd1);
    sendByte(1, SYNC);
    sendByte(1, 8'h01);
    sendByte(1, 8'h02);
    pulseReset();
    checkOutput("rst_valid1", {127'b0, out_valid[1]}, 128'd0);
    checkOutput("rst_data1", {32'b0, data1}, 128'd0);
    checkOutput("rst_count1", {112'b0, count1}, 128'd0);
    loadBytes(128'h1B1A1918_17161514_13121110, 12);
    applyStimulus(1, 12, 1'b0);
    checkOutput("after_rst_data", {32'b0, data1}, {32'b0, 96'h1B1A1918_17161514_13121110});
    checkOutput("after_rst_count", {112'b0, count1}, 128'd1);
    consume(1);

    repeat (4) @(negedge clk);
    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
